// File: rtl/pong_match_controller_if.sv
// Link between the match controller and the ball collision/motion block:
// ball and paddle geometry flow in, motion commands flow out.
interface pong_match_controller_if;
    logic [9:0] x_ball;
    logic [9:0] y_ball;
    logic [4:0] width_ball;
    logic [4:0] height_ball;
    logic       x_ball_dir;
    logic [9:0] y_lpad;
    logic [9:0] y_rpad;
    logic       ball_hold;
    logic       serve_dir;
    logic [3:0] x_ball_vel;
    logic [3:0] y_ball_vel;
    logic       bounce_l;
    logic       bounce_r;

    modport master (
        input  x_ball, y_ball, width_ball, height_ball, x_ball_dir, y_lpad, y_rpad,
        output ball_hold, serve_dir, x_ball_vel, y_ball_vel, bounce_l, bounce_r
    );

    modport slave (
        output x_ball, y_ball, width_ball, height_ball, x_ball_dir, y_lpad, y_rpad,
        input  ball_hold, serve_dir, x_ball_vel, y_ball_vel, bounce_l, bounce_r
    );
endinterface

// File: rtl/pong_match_controller.sv
// Pong match sequencer: serve/rally/point/game-over flow, paddle hit and miss
// detection, scoring and rally speed-up. Every output is registered.
module pong_match_controller #(
    parameter int unsigned WIN_SCORE        = 7,
    parameter int unsigned SERVE_TICKS      = 60,
    parameter int unsigned POINT_TICKS      = 30,
    parameter int unsigned HITS_PER_SPEEDUP = 4,
    parameter int unsigned VEL_BASE         = 2,
    parameter int unsigned VEL_MAX          = 8,
    parameter int unsigned X_LPAD           = 20,
    parameter int unsigned X_RPAD           = 610,
    parameter int unsigned PAD_H            = 48,
    parameter int unsigned MISS_X_L         = 8,
    parameter int unsigned MISS_X_R         = 624
) (
    input  logic                    game_clk,
    input  logic                    reset_n,
    input  logic                    start,
    pong_match_controller_if.master ball,
    output logic [3:0]              score_l,
    output logic [3:0]              score_r,
    output logic [2:0]              state,
    output logic                    winner
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam int unsigned TICK_MAX = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
    localparam int unsigned TICK_W   = $clog2(TICK_MAX + 1);
    localparam int unsigned HIT_W    = $clog2(HITS_PER_SPEEDUP + 1);
    localparam logic [TICK_W-1:0] SERVE_LAST = TICK_W'(SERVE_TICKS - 1);
    localparam logic [TICK_W-1:0] POINT_LAST = TICK_W'(POINT_TICKS - 1);

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [HIT_W-1:0]  hit_q, hit_d, hit_inc;
    logic [3:0]        x_vel_q, x_vel_d, y_vel_q, y_vel_d;
    logic [3:0]        score_l_q, score_l_d, score_r_q, score_r_d;
    logic              start_q, start_armed_q, start_armed_d;
    logic              lguard_q, lguard_d, rguard_q, rguard_d;
    logic              bounce_l_q, bounce_l_d, bounce_r_q, bounce_r_d;
    logic              hold_q, hold_d, serve_dir_q, serve_dir_d;
    logic              winner_q, winner_d, scorer_q, scorer_d;
    logic              enter_serve, point_won;
    logic              start_rise, left_hit, right_hit, left_miss, right_miss;
    logic [10:0]       ball_bottom, ball_right, lpad_bottom, rpad_bottom;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    // A start held through reset must be released before a rising edge counts.
    assign start_rise = start & ~start_q & start_armed_q;

    assign ball_bottom = {1'b0, ball.y_ball} + {6'd0, ball.height_ball};
    assign ball_right  = {1'b0, ball.x_ball} + {6'd0, ball.width_ball};
    assign lpad_bottom = {1'b0, ball.y_lpad} + 11'(PAD_H);
    assign rpad_bottom = {1'b0, ball.y_rpad} + 11'(PAD_H);

    assign left_hit  = ~ball.x_ball_dir && ({1'b0, ball.x_ball} <= 11'(X_LPAD)) &&
                       (ball_bottom >= {1'b0, ball.y_lpad}) &&
                       ({1'b0, ball.y_ball} <= lpad_bottom) && lguard_q;
    assign right_hit =  ball.x_ball_dir && (ball_right >= 11'(X_RPAD)) &&
                       (ball_bottom >= {1'b0, ball.y_rpad}) &&
                       ({1'b0, ball.y_ball} <= rpad_bottom) && rguard_q;
    assign left_miss  = ~ball.x_ball_dir && ({1'b0, ball.x_ball} <= 11'(MISS_X_L)) && ~left_hit;
    assign right_miss =  ball.x_ball_dir && (ball_right >= 11'(MISS_X_R)) && ~right_hit;

    assign hit_inc = hit_q + HIT_W'(1);

    always_comb begin
        state_d       = state_q;
        tick_d        = tick_q;
        hit_d         = hit_q;
        x_vel_d       = x_vel_q;
        y_vel_d       = y_vel_q;
        score_l_d     = score_l_q;
        score_r_d     = score_r_q;
        serve_dir_d   = serve_dir_q;
        winner_d      = winner_q;
        scorer_d      = scorer_q;
        bounce_l_d    = 1'b0;
        bounce_r_d    = 1'b0;
        start_armed_d = start_armed_q | ~start;
        lguard_d      = lguard_q | ball.x_ball_dir;
        rguard_d      = rguard_q | ~ball.x_ball_dir;
        enter_serve   = 1'b0;
        point_won     = 1'b0;

        case (state_q)
            IDLE: begin
                score_l_d = 4'd0;
                score_r_d = 4'd0;
                if (start_rise) begin
                    state_d     = SERVE;
                    serve_dir_d = 1'b1;
                    enter_serve = 1'b1;
                end
            end
            SERVE: begin
                tick_d = tick_q + TICK_W'(1);
                if (tick_q == SERVE_LAST) begin
                    state_d = PLAY;
                    tick_d  = '0;
                end
            end
            PLAY: begin
                if (left_hit || right_hit) begin
                    bounce_l_d = left_hit;
                    bounce_r_d = right_hit;
                    if (left_hit) lguard_d = 1'b0;
                    else          rguard_d = 1'b0;
                    if (hit_inc == HIT_W'(HITS_PER_SPEEDUP)) begin
                        hit_d = '0;
                        if (x_vel_q < 4'(VEL_MAX)) x_vel_d = x_vel_q + 4'd1;
                    end else begin
                        hit_d = hit_inc;
                    end
                end else if (left_miss || right_miss) begin
                    state_d     = POINT;
                    tick_d      = '0;
                    scorer_d    = left_miss;
                    serve_dir_d = ~left_miss;
                end
            end
            POINT: begin
                // The first POINT cycle is the only one with tick_q == 0, so the score moves once.
                tick_d = tick_q + TICK_W'(1);
                if (tick_q == '0) begin
                    if (scorer_q) score_r_d = sat_inc(score_r_q);
                    else          score_l_d = sat_inc(score_l_q);
                end
                point_won = ((scorer_q ? score_r_d : score_l_d) == 4'(WIN_SCORE));
                if (tick_q == POINT_LAST) begin
                    tick_d = '0;
                    if (point_won) begin
                        state_d  = OVER;
                        winner_d = scorer_q;
                    end else begin
                        state_d     = SERVE;
                        enter_serve = 1'b1;
                    end
                end
            end
            OVER: begin
                if (start_rise) begin
                    score_l_d   = 4'd0;
                    score_r_d   = 4'd0;
                    state_d     = SERVE;
                    serve_dir_d = 1'b1;
                    enter_serve = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_serve) begin
            tick_d   = '0;
            hit_d    = '0;
            x_vel_d  = 4'(VEL_BASE);
            y_vel_d  = 4'(VEL_BASE);
            lguard_d = 1'b1;
            rguard_d = 1'b1;
        end

        hold_d = (state_d != PLAY);
    end

    always_ff @(posedge game_clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            tick_q        <= '0;
            hit_q         <= '0;
            x_vel_q       <= 4'(VEL_BASE);
            y_vel_q       <= 4'(VEL_BASE);
            score_l_q     <= 4'd0;
            score_r_q     <= 4'd0;
            start_q       <= 1'b0;
            start_armed_q <= 1'b0;
            lguard_q      <= 1'b1;
            rguard_q      <= 1'b1;
            bounce_l_q    <= 1'b0;
            bounce_r_q    <= 1'b0;
            hold_q        <= 1'b1;
            serve_dir_q   <= 1'b1;
            winner_q      <= 1'b0;
            scorer_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_q        <= tick_d;
            hit_q         <= hit_d;
            x_vel_q       <= x_vel_d;
            y_vel_q       <= y_vel_d;
            score_l_q     <= score_l_d;
            score_r_q     <= score_r_d;
            start_q       <= start;
            start_armed_q <= start_armed_d;
            lguard_q      <= lguard_d;
            rguard_q      <= rguard_d;
            bounce_l_q    <= bounce_l_d;
            bounce_r_q    <= bounce_r_d;
            hold_q        <= hold_d;
            serve_dir_q   <= serve_dir_d;
            winner_q      <= winner_d;
            scorer_q      <= scorer_d;
        end
    end

    assign ball.ball_hold  = hold_q;
    assign ball.serve_dir  = serve_dir_q;
    assign ball.x_ball_vel = x_vel_q;
    assign ball.y_ball_vel = y_vel_q;
    assign ball.bounce_l   = bounce_l_q;
    assign ball.bounce_r   = bounce_r_q;
    assign score_l         = score_l_q;
    assign score_r         = score_r_q;
    assign state           = state_q;
    assign winner          = winner_q;

endmodule

// File: tb/tb_pong_match_controller.sv
// Bench for pong_match_controller: directed match scenarios plus a random rally,
// every cycle compared against a rule-level model of the match.
module tb_pong_match_controller;
    localparam int WIN = 7, ST = 60, PT = 30, HPS = 4, VB = 2, VM = 8;
    localparam int XL = 20, XR = 610, PH = 48, MXL = 8, MXR = 624;

    logic       game_clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [3:0] score_l, score_r;
    logic [2:0] state;
    logic       winner;
    int         passed = 0;
    int         total = 0;

    pong_match_controller_if bus();

    pong_match_controller #(
        .WIN_SCORE(WIN), .SERVE_TICKS(ST), .POINT_TICKS(PT), .HITS_PER_SPEEDUP(HPS),
        .VEL_BASE(VB), .VEL_MAX(VM), .X_LPAD(XL), .X_RPAD(XR), .PAD_H(PH),
        .MISS_X_L(MXL), .MISS_X_R(MXR)
    ) dut (
        .game_clk(game_clk), .reset_n(reset_n), .start(start), .ball(bus),
        .score_l(score_l), .score_r(score_r), .state(state), .winner(winner)
    );

    always #5 game_clk = ~game_clk;

    // Model: phase 0..4 = idle/serve/play/point/over, countdown of remaining ticks, total hits since serve.
    int m_phase, m_left, m_hits, m_sl, m_sr, m_pending, m_last;
    bit m_dir, m_winner, m_bl, m_br, m_lg, m_rg, m_start_prev, m_start_ok;

    task automatic modelReset();
        m_phase = 0; m_left = 0; m_hits = 0; m_sl = 0; m_sr = 0;
        m_pending = -1; m_last = 0; m_dir = 1; m_winner = 0;
        m_bl = 0; m_br = 0; m_lg = 1; m_rg = 1; m_start_prev = 0; m_start_ok = 0;
    endtask

    task automatic serveModel();
        m_phase = 1; m_left = ST; m_hits = 0; m_lg = 1; m_rg = 1;
    endtask

    task automatic modelStep();
        int x, y, w, h, ylp, yrp;
        bit d, rise, lhit, rhit;
        if (!reset_n) begin
            modelReset();
            return;
        end
        x = int'(bus.x_ball); y = int'(bus.y_ball);
        w = int'(bus.width_ball); h = int'(bus.height_ball);
        ylp = int'(bus.y_lpad); yrp = int'(bus.y_rpad); d = bus.x_ball_dir;
        rise = start && !m_start_prev && m_start_ok;
        m_start_ok = m_start_ok || !start;
        m_start_prev = start;
        m_bl = 0; m_br = 0;
        lhit = !d && x <= XL && y + h >= ylp && y <= ylp + PH && m_lg;
        rhit = d && x + w >= XR && y + h >= yrp && y <= yrp + PH && m_rg;
        if (d) m_lg = 1; else m_rg = 1;
        case (m_phase)
            0: if (rise) begin m_dir = 1; serveModel(); end
            1: begin m_left--; if (m_left == 0) m_phase = 2; end
            2: begin
                if (lhit) begin m_bl = 1; m_lg = 0; m_hits++; end
                else if (rhit) begin m_br = 1; m_rg = 0; m_hits++; end
                else if (!d && x <= MXL) begin m_phase = 3; m_left = PT; m_pending = 1; m_dir = 0; end
                else if (d && x + w >= MXR) begin m_phase = 3; m_left = PT; m_pending = 0; m_dir = 1; end
            end
            3: begin
                if (m_pending >= 0) begin
                    if (m_pending == 1) m_sr = (m_sr < 15) ? m_sr + 1 : 15;
                    else                m_sl = (m_sl < 15) ? m_sl + 1 : 15;
                    m_last = m_pending; m_pending = -1;
                end
                m_left--;
                if (m_left == 0) begin
                    if (((m_last == 1) ? m_sr : m_sl) == WIN) begin m_phase = 4; m_winner = (m_last == 1); end
                    else serveModel();
                end
            end
            4: if (rise) begin m_sl = 0; m_sr = 0; m_dir = 1; serveModel(); end
            default: ;
        endcase
    endtask

    function automatic int expVel();
        int v = VB + m_hits / HPS;
        return (v > VM) ? VM : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        total++;
        assert (obs === 32'(exp)) passed++;
        else $error("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic checkOutput();
        check("state",     32'(state),          m_phase);
        check("ball_hold", 32'(bus.ball_hold),  (m_phase != 2) ? 1 : 0);
        check("serve_dir", 32'(bus.serve_dir),  int'(m_dir));
        check("x_vel",     32'(bus.x_ball_vel), expVel());
        check("y_vel",     32'(bus.y_ball_vel), VB);
        check("bounce_l",  32'(bus.bounce_l),   int'(m_bl));
        check("bounce_r",  32'(bus.bounce_r),   int'(m_br));
        check("score_l",   32'(score_l),        m_sl);
        check("score_r",   32'(score_r),        m_sr);
        check("winner",    32'(winner),         int'(m_winner));
    endtask

    task automatic cycle();
        @(posedge game_clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic applyStimulus(input int x, input int y, input int w, input int h,
                                 input bit d, input int ylp, input int yrp);
        bus.x_ball = 10'(x); bus.y_ball = 10'(y);
        bus.width_ball = 5'(w); bus.height_ball = 5'(h);
        bus.x_ball_dir = d; bus.y_lpad = 10'(ylp); bus.y_rpad = 10'(yrp);
    endtask

    task automatic neutral();
        applyStimulus(300, 200, 8, 8, 1, 200, 200);
    endtask

    task automatic waitPhase(input int ph, input int budget);
        int n = 0;
        while (state !== 3'(ph) && n < budget) begin cycle(); n++; end
        if (state !== 3'(ph)) begin
            total++;
            $error("[TB] FAIL wait_state: got %0d, expected %0d", state, ph);
        end
    endtask

    // side 1 = right scores (left misses), side 0 = left scores.
    task automatic scorePoint(input bit side);
        waitPhase(2, 200);
        if (side) applyStimulus(6, 100, 8, 8, 0, 300, 300);
        else      applyStimulus(620, 100, 8, 8, 1, 300, 300);
        cycle();
        neutral();
    endtask

    task automatic randomStim();
        int sel = int'($urandom_range(0, 9));
        int ylp = int'($urandom_range(0, 431));
        int yrp = int'($urandom_range(0, 431));
        int w = int'($urandom_range(1, 31));
        int h = int'($urandom_range(1, 31));
        int x, y;
        bit d = 1'($urandom_range(0, 1));
        if (sel < 3)      x = int'($urandom_range(9, 22));
        else if (sel < 6) x = int'($urandom_range(585, 612));
        else              x = int'($urandom_range(0, 639));
        if (sel < 6) y = ((sel < 3) ? ylp : yrp) + int'($urandom_range(0, 80)) - 30;
        else         y = int'($urandom_range(0, 470));
        if (y < 0) y = 0;
        applyStimulus(x, y, w, h, d, ylp, yrp);
    endtask

    initial begin
        int pulses;
        modelReset();
        reset_n = 1'b0; start = 1'b0;
        neutral();
        cycle(); cycle();
        check("reset_state", 32'(state), 0);
        check("reset_hold", 32'(bus.ball_hold), 1);
        reset_n = 1'b1;
        cycle(); cycle();

        start = 1'b1; cycle(); start = 1'b0;
        check("start_serve", 32'(state), 1);
        repeat (ST - 1) cycle();
        check("serve_length", 32'(state), 1);
        cycle();
        check("play_entry", 32'(state), 2);
        check("play_hold", 32'(bus.ball_hold), 0);
        check("play_vel", 32'(bus.x_ball_vel), 2);

        applyStimulus(18, 100, 8, 8, 0, 80, 80);
        pulses = 0;
        repeat (6) begin cycle(); pulses += int'(bus.bounce_l); end
        check("lhit_single_pulse", 32'(pulses), 1);
        applyStimulus(300, 100, 8, 8, 1, 80, 80); cycle();
        applyStimulus(18, 100, 8, 8, 0, 80, 80); cycle();
        check("lhit_rearm", 32'(bus.bounce_l), 1);
        for (int i = 0; i < 26; i++) begin
            if (i % 2 == 0) applyStimulus(605, 100, 8, 8, 1, 80, 80);
            else            applyStimulus(18, 100, 8, 8, 0, 80, 80);
            cycle();
            if (i == 1)  check("speedup_first", 32'(bus.x_ball_vel), 3);
            if (i == 21) check("speedup_max", 32'(bus.x_ball_vel), 8);
            if (i == 25) check("speedup_sat", 32'(bus.x_ball_vel), 8);
        end

        applyStimulus(6, 100, 8, 8, 0, 300, 300); cycle();
        check("miss_point", 32'(state), 3);
        check("miss_score_early", 32'(score_r), 0);
        neutral(); cycle();
        check("miss_score", 32'(score_r), 1);
        repeat (PT - 2) cycle();
        check("point_length", 32'(state), 3);
        cycle();
        check("point_to_serve", 32'(state), 1);
        check("serve_toward_loser", 32'(bus.serve_dir), 0);
        check("serve_vel_reset", 32'(bus.x_ball_vel), 2);
        check("score_once", 32'(score_r), 1);

        waitPhase(2, 100);
        repeat (600) begin randomStim(); cycle(); end

        start = 1'b1; reset_n = 1'b0; neutral();
        cycle(); cycle();
        reset_n = 1'b1;
        repeat (3) cycle();
        check("held_start_idle", 32'(state), 0);
        start = 1'b0; cycle(); start = 1'b1; cycle(); start = 1'b0;
        check("restart_serve", 32'(state), 1);

        repeat (3) scorePoint(1'b0);
        repeat (2) scorePoint(1'b1);
        waitPhase(2, 200);
        check("rally_score_l", 32'(score_l), 3);
        check("rally_score_r", 32'(score_r), 2);
        applyStimulus(18, 100, 8, 8, 0, 80, 80);
        reset_n = 1'b0; cycle();
        check("midrst_state", 32'(state), 0);
        check("midrst_bounce", 32'(bus.bounce_l), 0);
        check("midrst_score_l", 32'(score_l), 0);
        cycle(); reset_n = 1'b1; neutral();
        cycle();
        check("postrst_bounce", 32'(bus.bounce_l), 0);

        start = 1'b1; cycle(); start = 1'b0;
        repeat (6) scorePoint(1'b1);
        start = 1'b1;
        scorePoint(1'b1);
        waitPhase(4, 200);
        check("over_winner", 32'(winner), 1);
        check("over_score_r", 32'(score_r), 7);
        repeat (5) cycle();
        check("over_held_start", 32'(state), 4);
        start = 1'b0; cycle(); start = 1'b1; cycle(); start = 1'b0;
        check("over_restart", 32'(state), 1);
        check("over_clear_r", 32'(score_r), 0);
        repeat (3) cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
